centroid_tracker: RTL and testbench
===================================

CENTROID_TRACKER -- requirements
Module: centroid_tracker

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- DEPTH, 4, history length in centroids; power of two, 2..16.
- SWIPE_DIST, 200, minimum horizontal travel in pixels for a swipe.
- LOST_FRAMES, 8, consecutive centroid-less frames before declaring lost.
- COOLDOWN_FRAMES, 15, frames ignored after a swipe.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk_in, input, 1, single clock.
- rst_in, input, 1, synchronous active-high reset.
- x_in, input, 11, raw centroid x from the centroid stage.
- y_in, input, 10, raw centroid y.
- valid_in, input, 1, one-cycle strobe qualifying x_in/y_in.
- frame_in, input, 1, one-cycle end-of-frame pulse.
- x_out, output, 11, filtered x.
- y_out, output, 10, filtered y.
- valid_out, output, 1, one-cycle strobe qualifying x_out/y_out.
- swipe_out, output, 2, gesture code: 01 right, 10 left, 00 none.
- swipe_valid_out, output, 1, one-cycle strobe qualifying swipe_out.
- lost_out, output, 1, level: target lost.

Function
REQ-003 Block SHALL hold a DEPTH-entry ring buffer of (x,y), a fill count 0..DEPTH, and running sums x_sum/y_sum wide enough for DEPTH*2047 (no overflow).
REQ-004 On valid_in, stage 1 (next edge) SHALL write the sample at the write pointer, advance the pointer mod DEPTH, and:
- fill==DEPTH: sum <= sum + new - evicted entry.
- otherwise: sum <= sum + new, fill += 1.
REQ-005 Stage 2 SHALL register outputs one edge later, so valid_out is high exactly 2 cycles after valid_in, for exactly 1 cycle.
REQ-006 If fill==DEPTH after the stage-1 update, x_out/y_out SHALL be sum >> log2(DEPTH) (truncating); otherwise they SHALL be the raw sample (pass-through).
REQ-007 valid_in SHALL be accepted back-to-back every cycle with no loss; no backpressure exists.
REQ-008 x_out/y_out SHALL hold their last value between valid_out strobes.
REQ-009 A miss counter SHALL be kept:
- frame_in with no valid_in since the previous frame_in increments it, saturating at LOST_FRAMES.
- Any valid_in clears it.
REQ-010 When the miss counter reaches LOST_FRAMES, lost_out SHALL rise on the next edge, and fill, sums and write pointer SHALL clear.
REQ-011 lost_out SHALL fall on the edge after the next valid_in; that sample is the first entry of the new history.
REQ-012 valid_in and frame_in in the same cycle SHALL count the sample toward the ending frame: the counter clears and does not increment.
REQ-013 Swipe FSM states SHALL be IDLE, TRACK, COOLDOWN; all transitions are evaluated on valid_out (filtered) samples or on frame_in.
REQ-014 IDLE -> TRACK SHALL occur on the first valid_out with fill==DEPTH, latching anchor = x_out.
REQ-015 In TRACK, each valid_out SHALL compute dx = x_out - anchor as a signed 12-bit value, then:
- dx >= SWIPE_DIST: swipe_out=01.
- dx <= -SWIPE_DIST: swipe_out=10.
- Either case: swipe_valid_out high 1 cycle (cycle after valid_out), cooldown counter loaded, state -> COOLDOWN.
REQ-016 COOLDOWN SHALL decrement on each frame_in and go to IDLE after COOLDOWN_FRAMES frame pulses.
REQ-017 lost_out rising SHALL force the FSM to IDLE from any state, suppressing any swipe in that cycle.
REQ-018 swipe_out SHALL be 00 whenever swipe_valid_out is low.

Reset
REQ-019 While rst_in is high at an edge, the block SHALL clear:
- x_out, y_out, valid_out, swipe_out, swipe_valid_out.
- fill, sums, pointer, miss counter, cooldown.
- FSM to IDLE.
lost_out SHALL also clear to 0.
REQ-020 Reset SHALL take priority over valid_in/frame_in in the same cycle; in-flight pipeline samples SHALL be discarded (no valid_out after reset).

Verification
REQ-021 Bench SHALL cover these directed scenarios:
- Fill: valid_in with x=100,104,108,112 (y=50) -> valid_out 2 cycles after each; x_out=100,104,108 (pass-through), then 106 ((100+104+108+112)>>2).
- Eviction: then x=200 -> x_out=(104+108+112+200)>>2=131.
- Swipe right: steady x=300 ×4 (anchor 300), then steps until filtered x>=500 -> one swipe_valid_out with swipe_out=01; the following 15 frames produce no swipe.
- Swipe left: anchor 900, filtered x falls to 700 -> swipe_out=10 on the sample where dx=-200 exactly.
- Lost: 8 frame_in pulses with no valid_in -> lost_out=1 after the 8th, fill=0; next valid_in x=40 -> x_out=40 (pass-through), lost_out=0.
- Simultaneity/reset: valid_in with frame_in after 7 misses -> no lost; rst_in asserted 1 cycle after valid_in -> no valid_out, all outputs 0.

Source files
------------

// File: rtl/centroid_tracker_if.sv
// rtl/centroid_tracker_if.sv - centroid sample and gesture bus between the centroid stage and its tracker
// Signals:
//   x_in/y_in/valid_in : raw centroid sample and its one-cycle qualifier
//   frame_in           : one-cycle end-of-frame pulse
//   x_out/y_out        : filtered centroid; valid_out qualifies it for one cycle
//   swipe_out          : gesture code (01 right, 10 left); swipe_valid_out qualifies it
//   lost_out           : level, target lost
// Modports: slave = tracker side, master = producer/consumer side.
interface centroid_tracker_if;
  logic [10:0] x_in;
  logic [9:0]  y_in;
  logic        valid_in;
  logic        frame_in;
  logic [10:0] x_out;
  logic [9:0]  y_out;
  logic        valid_out;
  logic [1:0]  swipe_out;
  logic        swipe_valid_out;
  logic        lost_out;

  modport slave (
    input  x_in, y_in, valid_in, frame_in,
    output x_out, y_out, valid_out, swipe_out, swipe_valid_out, lost_out
  );

  modport master (
    output x_in, y_in, valid_in, frame_in,
    input  x_out, y_out, valid_out, swipe_out, swipe_valid_out, lost_out
  );
endinterface

// File: rtl/centroid_tracker.sv
// rtl/centroid_tracker.sv - moving-average centroid filter with loss detection and horizontal swipe detection
// Ports:
//   clk_in : single clock
//   rst_in : synchronous active-high reset
//   bus    : centroid_tracker_if.slave (raw samples and frame pulse in; filtered samples,
//            swipe gesture and lost level out)
// Pipeline: stage 1 updates the history ring and running sums, stage 2 registers the
// filtered (or pass-through) sample. The swipe FSM watches the stage-2 output.
module centroid_tracker #(
  parameter int DEPTH           = 4,
  parameter int SWIPE_DIST      = 200,
  parameter int LOST_FRAMES     = 8,
  parameter int COOLDOWN_FRAMES = 15
) (
  input  logic               clk_in,
  input  logic               rst_in,
  centroid_tracker_if.slave  bus
);

  localparam int LOG    = $clog2(DEPTH);
  localparam int PTR_W  = LOG;
  localparam int FILL_W = $clog2(DEPTH + 1);
  localparam int SX_W   = 11 + LOG;
  localparam int SY_W   = 10 + LOG;
  localparam int MISS_W = $clog2(LOST_FRAMES + 1);
  localparam int COOL_W = $clog2(COOLDOWN_FRAMES + 1);

  localparam logic signed [11:0] SWIPE_POS = 12'(SWIPE_DIST);
  localparam logic signed [11:0] SWIPE_NEG = -SWIPE_POS;
  localparam logic [1:0]         SW_RIGHT  = 2'b01;
  localparam logic [1:0]         SW_LEFT   = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_TRACK,
    S_COOL
  } state_t;

  // history ring (contents only meaningful below the fill count, so never reset)
  logic [10:0] x_buf [DEPTH];
  logic [9:0]  y_buf [DEPTH];

  logic [PTR_W-1:0]  wp_q;
  logic [FILL_W-1:0] fill_q;
  logic [SX_W-1:0]   x_sum_q;
  logic [SY_W-1:0]   y_sum_q;

  logic              s1_valid_q;
  logic              s1_full_q;
  logic [10:0]       s1_x_q;
  logic [9:0]        s1_y_q;

  logic              valid_q;
  logic              full_q;
  logic [10:0]       x_q;
  logic [9:0]        y_q;

  logic [MISS_W-1:0] miss_q;
  logic              seen_q;
  logic              lost_q;
  logic              lost_set;
  logic              hist_full;

  state_t            state_q, state_d;
  logic [10:0]       anchor_q, anchor_d;
  logic [COOL_W-1:0] cool_q, cool_d;
  logic [1:0]        swipe_q, swipe_d;
  logic              swipe_valid_q, swipe_valid_d;
  logic signed [11:0] dx;

  assign hist_full = (fill_q == FILL_W'(DEPTH));

  // Lost fires once the miss count has saturated; a sample arriving in that very
  // cycle wins, since it clears the miss count and starts a fresh frame.
  assign lost_set = (miss_q == MISS_W'(LOST_FRAMES)) && !lost_q && !bus.valid_in;

  always_ff @(posedge clk_in) begin
    if (!rst_in && bus.valid_in) begin
      x_buf[wp_q] <= bus.x_in;
      y_buf[wp_q] <= bus.y_in;
    end
  end

  // stage 1: history bookkeeping and loss state
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wp_q       <= '0;
      fill_q     <= '0;
      x_sum_q    <= '0;
      y_sum_q    <= '0;
      s1_valid_q <= 1'b0;
      s1_full_q  <= 1'b0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      lost_q     <= 1'b0;
    end else begin
      s1_valid_q <= bus.valid_in;
      if (lost_set) begin
        wp_q    <= '0;
        fill_q  <= '0;
        x_sum_q <= '0;
        y_sum_q <= '0;
        lost_q  <= 1'b1;
      end else if (bus.valid_in) begin
        wp_q      <= wp_q + PTR_W'(1);
        s1_x_q    <= bus.x_in;
        s1_y_q    <= bus.y_in;
        s1_full_q <= hist_full || (fill_q == FILL_W'(DEPTH - 1));
        lost_q    <= 1'b0;
        if (hist_full) begin
          // slot at the write pointer is the oldest entry being overwritten
          x_sum_q <= x_sum_q + SX_W'(bus.x_in) - SX_W'(x_buf[wp_q]);
          y_sum_q <= y_sum_q + SY_W'(bus.y_in) - SY_W'(y_buf[wp_q]);
        end else begin
          x_sum_q <= x_sum_q + SX_W'(bus.x_in);
          y_sum_q <= y_sum_q + SY_W'(bus.y_in);
          fill_q  <= fill_q + FILL_W'(1);
        end
      end
    end
  end

  // stage 2: the sums already reflect the stage-1 sample here
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_q <= 1'b0;
      full_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        full_q <= s1_full_q;
        x_q    <= s1_full_q ? 11'(x_sum_q >> LOG) : s1_x_q;
        y_q    <= s1_full_q ? 10'(y_sum_q >> LOG) : s1_y_q;
      end
    end
  end

  // Miss counter: seen_q remembers a sample in the current frame. A sample
  // coinciding with frame_in belongs to the frame that is ending.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      miss_q <= '0;
      seen_q <= 1'b0;
    end else if (bus.valid_in) begin
      miss_q <= '0;
      seen_q <= !bus.frame_in;
    end else if (bus.frame_in) begin
      if (seen_q) begin
        seen_q <= 1'b0;
      end else if (miss_q != MISS_W'(LOST_FRAMES)) begin
        miss_q <= miss_q + MISS_W'(1);
      end
    end
  end

  assign dx = $signed({1'b0, x_q}) - $signed({1'b0, anchor_q});

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q       <= S_IDLE;
      anchor_q      <= '0;
      cool_q        <= '0;
      swipe_q       <= '0;
      swipe_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      anchor_q      <= anchor_d;
      cool_q        <= cool_d;
      swipe_q       <= swipe_d;
      swipe_valid_q <= swipe_valid_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    anchor_d      = anchor_q;
    cool_d        = cool_q;
    swipe_d       = 2'b00;
    swipe_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (valid_q && full_q) begin
          state_d  = S_TRACK;
          anchor_d = x_q;
        end
      end
      S_TRACK: begin
        if (valid_q) begin
          if (dx >= SWIPE_POS) begin
            swipe_d       = SW_RIGHT;
            swipe_valid_d = 1'b1;
            cool_d        = COOL_W'(COOLDOWN_FRAMES);
            state_d       = S_COOL;
          end else if (dx <= SWIPE_NEG) begin
            swipe_d       = SW_LEFT;
            swipe_valid_d = 1'b1;
            cool_d        = COOL_W'(COOLDOWN_FRAMES);
            state_d       = S_COOL;
          end
        end
      end
      S_COOL: begin
        if (bus.frame_in) begin
          if (cool_q <= COOL_W'(1)) begin
            cool_d  = '0;
            state_d = S_IDLE;
          end else begin
            cool_d = cool_q - COOL_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // losing the target overrides anything decided this cycle
    if (lost_set) begin
      state_d       = S_IDLE;
      cool_d        = '0;
      swipe_d       = 2'b00;
      swipe_valid_d = 1'b0;
    end
  end

  assign bus.x_out           = x_q;
  assign bus.y_out           = y_q;
  assign bus.valid_out       = valid_q;
  assign bus.swipe_out       = swipe_q;
  assign bus.swipe_valid_out = swipe_valid_q;
  assign bus.lost_out        = lost_q;

endmodule

// File: tb/tb_centroid_tracker.sv
// tb/tb_centroid_tracker.sv - directed scoreboard bench for centroid_tracker
module tb_centroid_tracker;
  localparam int DEPTH           = 4;
  localparam int SWIPE_DIST      = 200;
  localparam int LOST_FRAMES     = 8;
  localparam int COOLDOWN_FRAMES = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   last_vo_cyc = -100;

  typedef struct {
    logic [10:0] x;
    logic [9:0]  y;
    int          cyc;
  } samp_t;

  samp_t      exp_q[$];
  logic [1:0] swipe_q[$];
  int         hist_x[$];
  int         hist_y[$];

  centroid_tracker_if bus();

  centroid_tracker #(
    .DEPTH(DEPTH),
    .SWIPE_DIST(SWIPE_DIST),
    .LOST_FRAMES(LOST_FRAMES),
    .COOLDOWN_FRAMES(COOLDOWN_FRAMES)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    samp_t e;
    if (cyc > 0) begin
      if (bus.valid_out === 1'b1) begin
        last_vo_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_valid_out", 32'(bus.valid_out), 32'h0);
        end else begin
          e = exp_q.pop_front();
          check("x_out", 32'(bus.x_out), 32'(e.x));
          check("y_out", 32'(bus.y_out), 32'(e.y));
          check("valid_latency", 32'(cyc - e.cyc), 32'd2);
        end
      end
      if (bus.swipe_valid_out === 1'b1) begin
        if (swipe_q.size() == 0) begin
          check("unexpected_swipe_valid", 32'(bus.swipe_valid_out), 32'h0);
        end else begin
          check("swipe_out", 32'(bus.swipe_out), 32'(swipe_q.pop_front()));
          check("swipe_latency", 32'(cyc - last_vo_cyc), 32'd1);
        end
      end else begin
        check("swipe_out_idle", 32'(bus.swipe_out), 32'h0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int x, input int y, input bit framed);
    samp_t e;
    int sx, sy;
    hist_x.push_back(x);
    hist_y.push_back(y);
    if (hist_x.size() > DEPTH) begin
      void'(hist_x.pop_front());
      void'(hist_y.pop_front());
    end
    if (hist_x.size() == DEPTH) begin
      sx = 0;
      sy = 0;
      foreach (hist_x[i]) begin
        sx += hist_x[i];
        sy += hist_y[i];
      end
      e.x = 11'(sx / DEPTH);
      e.y = 10'(sy / DEPTH);
    end else begin
      e.x = 11'(x);
      e.y = 10'(y);
    end
    e.cyc = cyc;
    exp_q.push_back(e);
    bus.x_in     = 11'(x);
    bus.y_in     = 10'(y);
    bus.valid_in = 1'b1;
    bus.frame_in = framed;
    tick(1);
    bus.valid_in = 1'b0;
    bus.frame_in = 1'b0;
  endtask

  task automatic frame_pulse();
    bus.frame_in = 1'b1;
    tick(1);
    bus.frame_in = 1'b0;
    tick(1);
  endtask

  task automatic clear_model();
    hist_x.delete();
    hist_y.delete();
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    clear_model();
  endtask

  task automatic check_all_zero(input string tag);
    @(negedge clk);
    check({tag, "_x_out"}, 32'(bus.x_out), 32'h0);
    check({tag, "_y_out"}, 32'(bus.y_out), 32'h0);
    check({tag, "_valid_out"}, 32'(bus.valid_out), 32'h0);
    check({tag, "_swipe_out"}, 32'(bus.swipe_out), 32'h0);
    check({tag, "_swipe_valid"}, 32'(bus.swipe_valid_out), 32'h0);
    check({tag, "_lost_out"}, 32'(bus.lost_out), 32'h0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_lost(input string tag, input logic exp);
    @(negedge clk);
    check(tag, 32'(bus.lost_out), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.x_in     = '0;
    bus.y_in     = '0;
    bus.valid_in = 1'b0;
    bus.frame_in = 1'b0;
    rst          = 1'b1;
    tick(3);
    rst = 1'b0;
    check_all_zero("reset");

    // fill then eviction
    send(100, 50, 1'b0);
    send(104, 50, 1'b0);
    send(108, 50, 1'b0);
    send(112, 50, 1'b0);
    send(200, 50, 1'b0);
    tick(4);

    // swipe right from a fresh history anchored at 300
    reset_pulse();
    tick(2);
    repeat (4) send(300, 60, 1'b0);
    repeat (3) send(500, 60, 1'b0);
    swipe_q.push_back(2'b01);
    send(500, 60, 1'b0);
    tick(5);
    check("swipe_right_delivered", 32'(swipe_q.size()), 32'h0);
    // cooldown: large jumps during the following frames must not swipe
    for (int i = 1; i <= COOLDOWN_FRAMES; i++) begin
      frame_pulse();
      if (i < COOLDOWN_FRAMES) send(900, 60, 1'b0);
      tick(3);
    end
    tick(4);

    // swipe left anchored at 900, fires exactly at dx = -200
    reset_pulse();
    tick(2);
    repeat (4) send(900, 70, 1'b0);
    repeat (3) send(700, 70, 1'b0);
    swipe_q.push_back(2'b10);
    send(700, 70, 1'b0);
    tick(5);
    check("swipe_left_delivered", 32'(swipe_q.size()), 32'h0);

    // lost: close the frame that had samples, then 8 empty frames
    frame_pulse();
    repeat (LOST_FRAMES - 1) frame_pulse();
    tick(2);
    check_lost("lost_before_limit", 1'b0);
    frame_pulse();
    tick(2);
    check_lost("lost_after_limit", 1'b1);
    clear_model();
    send(40, 80, 1'b0);
    check_lost("lost_cleared_by_sample", 1'b0);
    send(44, 80, 1'b0);
    tick(4);

    // simultaneity: sample with the frame pulse after 7 misses
    frame_pulse();
    repeat (LOST_FRAMES - 1) frame_pulse();
    send(60, 90, 1'b1);
    tick(3);
    check_lost("simul_no_lost", 1'b0);
    repeat (LOST_FRAMES - 1) frame_pulse();
    tick(2);
    check_lost("simul_seven_after", 1'b0);
    frame_pulse();
    tick(2);
    check_lost("simul_eighth_after", 1'b1);
    clear_model();

    // reset one cycle after a sample discards it
    bus.x_in     = 11'd555;
    bus.y_in     = 10'd99;
    bus.valid_in = 1'b1;
    tick(1);
    bus.valid_in = 1'b0;
    rst          = 1'b1;
    tick(1);
    rst = 1'b0;
    clear_model();
    tick(4);
    check_all_zero("inflight_reset");

    tick(4);
    check("samples_drained", 32'(exp_q.size()), 32'h0);
    check("swipes_drained", 32'(swipe_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
